// File: rtl/memory_cpc6128_banked.sv
// CPC 6128-class memory manager: RAM banking, upper-ROM select and registered SRAM sequencer.
// Define CPC_RAM_EXPANSION_EN to honour the 7Fxx expansion page bits data[5:3].
module memory_cpc6128_banked #(
    parameter int unsigned SRAM_AW       = 21,
    parameter int unsigned NUM_EXP_PAGES = 1,
    parameter int unsigned NUM_UROMS     = 8,
    parameter int unsigned ROM_BASE_PAGE = 16,
    parameter int unsigned RD_LAT        = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        cpu_addr,
    input  logic               iorq_n,
    input  logic               wr_n,
    input  logic [7:0]         data_from_cpu,
    input  logic [15:0]        vram_addr,
    input  logic               ready,
    input  logic               cpu_n,
    input  logic               romen_n,
    input  logic               ramrd_n,
    input  logic               ras_n,
    input  logic               cas_n,
    input  logic               mwe_n,
    input  logic               en244_n,
    output logic [7:0]         data_to_cpu,
    output logic               memory_oe_n,
    output logic [7:0]         data_to_ga,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [7:0]         sram_data,
    output logic               sram_we_n
);
    localparam int unsigned        PW       = SRAM_AW - 16;
    localparam logic [2:0]         RdLat    = 3'(RD_LAT);
    localparam logic [8:0]         NumUroms = 9'(NUM_UROMS);
    localparam logic [SRAM_AW-1:0] RomBase  = SRAM_AW'(ROM_BASE_PAGE) << 16;

    typedef enum logic [2:0] {StIdle, StCpuRd, StCpuWr, StVidRd, StRomRd} state_e;

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [1:0]         ras_sync_q, ras_sync_d, cas_sync_q, cas_sync_d;
    logic               cas_prev_q, cas_prev_d;
    logic               io_wr_q, io_wr_d;
    logic [2:0]         ram_cfg_q, ram_cfg_d;
    logic [7:0]         urom_sel_q, urom_sel_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic               sram_we_n_q, sram_we_n_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         cpu_latch_q, cpu_latch_d;
    logic [7:0]         vid_latch_q, vid_latch_d;
    logic [7:0]         rom_latch_q, rom_latch_d;
`ifdef CPC_RAM_EXPANSION_EN
    localparam logic [2:0] MaxExp = 3'(NUM_EXP_PAGES - 1);
    logic [2:0]         exp_page_q, exp_page_d;
`endif

    logic [1:0]         blk;
    logic [2:0]         phys_blk, exp_eff;
    logic [PW-1:0]      ram_page;
    logic [8:0]         rom_slot;
    logic [SRAM_AW-1:0] cpu_ram_addr, vid_addr, rom_addr;
    logic               cas_s, ras_s, ram_start, io_wr;

    // Address decode: 16KB CPU block -> physical block -> SRAM page/slot.
    always_comb begin
        blk      = cpu_addr[15:14];
        phys_blk = {1'b0, blk};
        unique case (ram_cfg_q)
            3'd1: if (blk == 2'd3) phys_blk = 3'd7;
            3'd2: phys_blk = {1'b1, blk};
            3'd3: begin
                if (blk == 2'd1) phys_blk = 3'd3;
                else if (blk == 2'd3) phys_blk = 3'd7;
            end
            3'd4, 3'd5, 3'd6, 3'd7: if (blk == 2'd1) phys_blk = {1'b1, ram_cfg_q[1:0]};
            default: ;
        endcase
`ifdef CPC_RAM_EXPANSION_EN
        exp_eff = (exp_page_q > MaxExp) ? MaxExp : exp_page_q;
`else
        exp_eff = 3'd0;
`endif
        ram_page     = phys_blk[2] ? PW'(exp_eff) + PW'(1) : '0;
        cpu_ram_addr = {ram_page, phys_blk[1:0], cpu_addr[13:0]};
        vid_addr     = {{PW{1'b0}}, vram_addr};
        if (!cpu_addr[15]) rom_slot = 9'd0;
        else if ({1'b0, urom_sel_q} >= NumUroms) rom_slot = 9'd1;
        else rom_slot = {1'b0, urom_sel_q} + 9'd1;
        rom_addr = RomBase + SRAM_AW'({rom_slot, cpu_addr[13:0]});
    end

    assign cas_s     = cas_sync_q[1];
    assign ras_s     = ras_sync_q[1];
    assign ram_start = cas_prev_q && !cas_s && !ras_s;
    assign io_wr     = !iorq_n && !wr_n;

    always_comb begin
        ras_sync_d  = {ras_sync_q[0], ras_n};
        cas_sync_d  = {cas_sync_q[0], cas_n};
        cas_prev_d  = cas_s;
        io_wr_d     = io_wr;
        ram_cfg_d   = ram_cfg_q;
        urom_sel_d  = urom_sel_q;
`ifdef CPC_RAM_EXPANSION_EN
        exp_page_d  = exp_page_q;
`endif
        state_d     = state_q;
        cnt_d       = cnt_q;
        sram_addr_d = sram_addr_q;
        sram_we_n_d = sram_we_n_q;
        wdata_d     = wdata_q;
        cpu_latch_d = cpu_latch_q;
        vid_latch_d = vid_latch_q;
        rom_latch_d = rom_latch_q;

        if (io_wr && !io_wr_q) begin
            if (!cpu_addr[15] && data_from_cpu[7:6] == 2'b11) begin
                ram_cfg_d = data_from_cpu[2:0];
`ifdef CPC_RAM_EXPANSION_EN
                exp_page_d = data_from_cpu[5:3];
`endif
            end
            if (!cpu_addr[13]) urom_sel_d = data_from_cpu;
        end

        // A RAM cycle pre-empts an in-flight ROM read; the ROM read reissues from idle.
        if ((state_q == StIdle || state_q == StRomRd) && ram_start) begin
            cnt_d = 3'd1;
            if (cpu_n) begin
                state_d     = StVidRd;
                sram_addr_d = vid_addr;
            end else begin
                state_d     = mwe_n ? StCpuRd : StCpuWr;
                sram_addr_d = cpu_ram_addr;
                wdata_d     = data_from_cpu;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!romen_n) begin
                        state_d     = StRomRd;
                        sram_addr_d = rom_addr;
                        cnt_d       = 3'd1;
                    end
                end
                StRomRd: begin
                    if (cnt_q == RdLat) begin
                        rom_latch_d = sram_data;
                        state_d     = StIdle;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StCpuRd, StVidRd: begin
                    if (cas_s) begin
                        state_d = StIdle;
                    end else if (cnt_q == RdLat) begin
                        if (state_q == StVidRd) vid_latch_d = sram_data;
                        else if (ready) cpu_latch_d = sram_data;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StCpuWr: begin
                    if (cas_s) begin
                        sram_we_n_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        sram_we_n_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            ras_sync_q  <= 2'b11;
            cas_sync_q  <= 2'b11;
            cas_prev_q  <= 1'b1;
            io_wr_q     <= 1'b0;
            ram_cfg_q   <= 3'd0;
            urom_sel_q  <= 8'd0;
`ifdef CPC_RAM_EXPANSION_EN
            exp_page_q  <= 3'd0;
`endif
            sram_addr_q <= '0;
            sram_we_n_q <= 1'b1;
            wdata_q     <= 8'd0;
            cpu_latch_q <= 8'hFF;
            vid_latch_q <= 8'hFF;
            rom_latch_q <= 8'hFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ras_sync_q  <= ras_sync_d;
            cas_sync_q  <= cas_sync_d;
            cas_prev_q  <= cas_prev_d;
            io_wr_q     <= io_wr_d;
            ram_cfg_q   <= ram_cfg_d;
            urom_sel_q  <= urom_sel_d;
`ifdef CPC_RAM_EXPANSION_EN
            exp_page_q  <= exp_page_d;
`endif
            sram_addr_q <= sram_addr_d;
            sram_we_n_q <= sram_we_n_d;
            wdata_q     <= wdata_d;
            cpu_latch_q <= cpu_latch_d;
            vid_latch_q <= vid_latch_d;
            rom_latch_q <= rom_latch_d;
        end
    end

    always_comb begin
        if (!romen_n) begin
            data_to_cpu = rom_latch_q;
            memory_oe_n = 1'b0;
        end else if (!ramrd_n) begin
            data_to_cpu = cpu_latch_q;
            memory_oe_n = 1'b0;
        end else begin
            data_to_cpu = 8'hFF;
            memory_oe_n = 1'b1;
        end
        data_to_ga = en244_n ? vid_latch_q : data_from_cpu;
    end

    assign sram_addr = sram_addr_q;
    assign sram_we_n = sram_we_n_q;
    assign sram_data = sram_we_n_q ? 8'hzz : wdata_q;

endmodule

// File: tb/tb_memory_cpc6128_banked.sv
// Randomised bench for memory_cpc6128_banked: behavioural banking/ROM model, SRAM model, scoreboard.
module tb_memory_cpc6128_banked;
    localparam int AW = 21, NEXP = 7, NUR = 8, RBP = 16, RDL = 2;
    localparam int MAP [8][4] = '{'{0,1,2,3}, '{0,1,2,7}, '{4,5,6,7}, '{0,3,2,7},
                                  '{0,4,2,3}, '{0,5,2,3}, '{0,6,2,3}, '{0,7,2,3}};

    logic clk = 1'b0, reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0, vram_addr = 16'h0;
    logic iorq_n = 1, wr_n = 1, ready = 1, cpu_n = 0, romen_n = 1, ramrd_n = 1;
    logic ras_n = 1, cas_n = 1, mwe_n = 1, en244_n = 1;
    logic [7:0] data_from_cpu = 8'h0, data_to_cpu, data_to_ga, sram_drv = 8'hFF;
    logic memory_oe_n, sram_we_n;
    logic [AW-1:0] sram_addr;
    wire  [7:0] sram_data;

    assign sram_data = sram_we_n ? sram_drv : 8'hzz;

    memory_cpc6128_banked #(.SRAM_AW(AW), .NUM_EXP_PAGES(NEXP), .NUM_UROMS(NUR),
                            .ROM_BASE_PAGE(RBP), .RD_LAT(RDL)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .iorq_n(iorq_n), .wr_n(wr_n),
        .data_from_cpu(data_from_cpu), .vram_addr(vram_addr), .ready(ready), .cpu_n(cpu_n),
        .romen_n(romen_n), .ramrd_n(ramrd_n), .ras_n(ras_n), .cas_n(cas_n), .mwe_n(mwe_n),
        .en244_n(en244_n), .data_to_cpu(data_to_cpu), .memory_oe_n(memory_oe_n),
        .data_to_ga(data_to_ga), .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_we_n(sram_we_n));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit quiet = 0;
    logic [7:0] phys [int];
    logic [7:0] expm [int];
    int m_cfg = 0, m_exp = 0, m_urom = 0;
    logic [7:0] m_cpu = 8'hFF, m_vid = 8'hFF, m_rom = 8'hFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] dflt(input int a);
        return 8'(a ^ (a >> 8) ^ (a >> 16) ^ 32'h5A);
    endfunction
    function automatic logic [7:0] rd_phys(input int a);
        if (phys.exists(a)) return phys[a];
        return dflt(a);
    endfunction
    function automatic logic [7:0] rd_exp(input int a);
        if (expm.exists(a)) return expm[a];
        return dflt(a);
    endfunction

    function automatic int ram_addr(input int cfg, input int ex, input logic [15:0] a);
        int p, ee;
        p = MAP[cfg][int'(a[15:14])];
`ifdef CPC_RAM_EXPANSION_EN
        ee = (ex > NEXP - 1) ? NEXP - 1 : ex;
`else
        ee = 0;
`endif
        return ((p < 4) ? 0 : 1 + ee) * 65536 + (p % 4) * 16384 + int'(a[13:0]);
    endfunction

    function automatic int rom_addr(input int urom, input logic [15:0] a);
        int slot;
        if (!a[15]) slot = 0;
        else if (urom >= NUR) slot = 1;
        else slot = 1 + urom;
        return RBP * 65536 + slot * 16384 + int'(a[13:0]);
    endfunction

    // External SRAM: writes land on posedges with the strobe low, reads are asynchronous.
    always @(posedge clk) begin
        if (!sram_we_n) phys[int'(sram_addr)] = sram_data;
        #1 sram_drv = rd_phys(int'(sram_addr));
    end

    always @(negedge clk) begin
        if (quiet && !reset) begin
            check("data_to_cpu", {24'h0, data_to_cpu},
                  {24'h0, !romen_n ? m_rom : (!ramrd_n ? m_cpu : 8'hFF)});
            check("memory_oe_n", {31'h0, memory_oe_n}, {31'h0, romen_n && ramrd_n});
            check("data_to_ga", {24'h0, data_to_ga}, {24'h0, en244_n ? m_vid : data_from_cpu});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cfg = 0; m_exp = 0; m_urom = 0;
        m_cpu = 8'hFF; m_vid = 8'hFF; m_rom = 8'hFF;
    endtask

    task automatic io_out(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; data_from_cpu = d; iorq_n = 0; wr_n = 0;
        tick(2);
        iorq_n = 1; wr_n = 1;
        tick(1);
        if (!a[15] && d[7:6] == 2'b11) begin
            m_cfg = int'(d[2:0]);
            m_exp = int'(d[5:3]);
        end
        if (!a[13]) m_urom = int'(d);
    endtask

    // kind: 0 CPU read, 1 CPU write, 2 video read.
    task automatic ram_cycle(input int kind, input logic [15:0] a, input logic [7:0] d,
                             input logic rdy, output int seen);
        int ea;
        logic we_seen;
        quiet = 0; romen_n = 1;
        tick(RDL + 4);
        ea = (kind == 2) ? int'(a) : ram_addr(m_cfg, m_exp, a);
        if (kind == 2) vram_addr = a; else cpu_addr = a;
        data_from_cpu = d; ready = rdy; cpu_n = (kind == 2); mwe_n = (kind != 1);
        ramrd_n = 1'($urandom); en244_n = 1'($urandom);
        ras_n = 0;
        tick(1);
        cas_n = 0;
        tick(8);
        seen = int'(sram_addr);
        we_seen = sram_we_n;
        cas_n = 1; ras_n = 1;
        tick(4);
        check("sram_addr", seen, ea);
        if (kind == 1) begin
            check("sram_we_n_low", {31'h0, we_seen}, 32'h0);
            expm[ea] = d;
        end else if (kind == 0) begin
            if (rdy) m_cpu = rd_exp(ea);
        end else begin
            m_vid = rd_exp(ea);
        end
        mwe_n = 1;
        quiet = 1;
    endtask

    task automatic rom_read(input logic [15:0] a, output int seen);
        quiet = 0;
        cpu_addr = a; romen_n = 0; en244_n = 1'($urandom);
        tick(2 * RDL + 6);
        seen = int'(sram_addr);
        check("rom_sram_addr", seen, rom_addr(m_urom, a));
        m_rom = rd_exp(rom_addr(m_urom, a));
        quiet = 1;
        tick(3);
        romen_n = 1;
        tick(RDL + 3);
    endtask

    task automatic abort_read(input logic [15:0] a);
        quiet = 0; romen_n = 1;
        tick(RDL + 4);
        cpu_addr = a; cpu_n = 0; mwe_n = 1; ready = 1;
        ras_n = 0;
        tick(1);
        cas_n = 0;
        tick(1);
        cas_n = 1;
        tick(RDL + 6);
        ras_n = 1;
        tick(2);
        quiet = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [15:0] ra;
        tick(3);
        check("rst_data_to_cpu", {24'h0, data_to_cpu}, 32'hFF);
        check("rst_oe_n", {31'h0, memory_oe_n}, 32'h1);
        check("rst_we_n", {31'h0, sram_we_n}, 32'h1);
        check("rst_sram_addr", {11'h0, sram_addr}, 32'h0);
        check("rst_data_to_ga", {24'h0, data_to_ga}, 32'hFF);
        reset = 0;
        tick(2);
        quiet = 1;

        io_out(16'h7F00, 8'hC2);
        ram_cycle(1, 16'h4000, 8'h55, 1'b1, seen);
        check("c2_wr_addr", seen, 32'h14000);
        ram_cycle(0, 16'h4000, 8'h00, 1'b1, seen);
        ramrd_n = 0; romen_n = 1;
        tick(1);
        check("c2_readback", {24'h0, data_to_cpu}, 32'h55);

        io_out(16'h7F00, 8'hC4);
        ram_cycle(1, 16'h4000, 8'hAA, 1'b1, seen);
        check("c4_wr_addr", seen, 32'h10000);
        ram_cycle(2, 16'h4000, 8'h00, 1'b1, seen);
        check("vid_addr", seen, 32'h04000);
        en244_n = 1;
        tick(1);
        check("vid_byte", {24'h0, data_to_ga}, 32'h1A);

        io_out(16'h7F00, 8'hD6);
        ram_cycle(1, 16'h4000, 8'h3E, 1'b1, seen);
`ifdef CPC_RAM_EXPANSION_EN
        check("d6_wr_addr", seen, 32'h38000);
`else
        check("d6_wr_addr", seen, 32'h18000);
`endif

        io_out(16'hDF00, 8'h07);
        rom_read(16'hC123, seen);
        check("urom7_addr", seen, 32'h120123);
        io_out(16'hDF00, 8'hFF);
        rom_read(16'hC123, seen);
        check("urom_fallback", seen, 32'h104123);
        rom_read(16'h0123, seen);
        check("lower_rom", seen, 32'h100123);

        io_out(16'h7F00, 8'hC0);
        ram_cycle(1, 16'h1234, 8'h77, 1'b1, seen);
        ram_cycle(0, 16'h1234, 8'h00, 1'b1, seen);
        ram_cycle(1, 16'h1234, 8'h88, 1'b1, seen);
        ram_cycle(0, 16'h1234, 8'h00, 1'b0, seen);
        ramrd_n = 0;
        tick(1);
        check("ready0_hold", {24'h0, data_to_cpu}, 32'h77);
        ram_cycle(1, 16'h2000, 8'h99, 1'b1, seen);
        ramrd_n = 0;
        abort_read(16'h2000);
        check("abort_hold", {24'h0, data_to_cpu}, 32'h77);

        // Reset asserted while the write strobe is active.
        quiet = 0; romen_n = 1; ramrd_n = 1;
        tick(RDL + 4);
        cpu_addr = 16'h8000; data_from_cpu = 8'h3C; cpu_n = 0; mwe_n = 0;
        ras_n = 0;
        tick(1);
        cas_n = 0;
        tick(5);
        check("mid_wr_we_low", {31'h0, sram_we_n}, 32'h0);
        expm[ram_addr(m_cfg, m_exp, 16'h8000)] = 8'h3C;
        #2 reset = 1;
        #1;
        check("mid_rst_we_n", {31'h0, sram_we_n}, 32'h1);
        check("mid_rst_data_to_cpu", {24'h0, data_to_cpu}, 32'hFF);
        check("mid_rst_oe_n", {31'h0, memory_oe_n}, 32'h1);
        cas_n = 1; ras_n = 1; mwe_n = 1;
        tick(3);
        reset = 0;
        model_reset();
        tick(2);
        quiet = 1;

        for (int i = 0; i < 60; i++) begin
            ra = 16'(($urandom % 4) << 14) | 16'($urandom % 4);
            case ($urandom % 5)
                0: begin
                    case ($urandom % 3)
                        0: io_out(16'h7F00, 8'hC0 | 8'($urandom % 64));
                        1: io_out(16'h5F00, 8'($urandom));
                        default: io_out(16'h7F00, 8'($urandom));
                    endcase
                end
                1: io_out(16'hDF00, 8'($urandom % 12));
                2: ram_cycle(1, ra, 8'($urandom), 1'b1, seen);
                3: ram_cycle(($urandom % 2 == 0) ? 0 : 2, ra, 8'h00, 1'($urandom), seen);
                default: rom_read(16'($urandom), seen);
            endcase
        end
        ram_cycle(0, 16'h8000, 8'h00, 1'b1, seen);
        tick(2);
        quiet = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
